// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller: FSM encodings, reference
// truth tables and the truth-table lookup helper.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int N_IN_MAX = 4;

  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_XOR2 = 4'b0110;

  // Truth tables are zero-padded to the widest supported gate so one helper
  // serves every N_IN.
  function automatic logic tt_expected(input logic [15:0] tt, input logic [3:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate_sweep_controller.sv
// Walks an N_IN-input gate through all input vectors, samples gate_y after a
// settle delay and scores each sample against the expected truth table.
module gate_sweep_controller
  import gate_sweep_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]    EXP_TT = TT_AND2,
  parameter int                      SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  IDX_LAST    = {N_IN{1'b1}};
  localparam logic [15:0]      TT_PAD      = 16'(EXP_TT);

  state_t            state_r;
  state_t            state_s;
  logic [N_IN-1:0]   idx_r;
  logic [CNT_W-1:0]  settle_r;
  logic [N_IN:0]     err_count_r;
  logic [N_IN-1:0]   first_fail_r;
  logic              expected_s;
  logic              mismatch_s;
  logic              settle_last_s;
  logic              idx_last_s;
  logic              busy_s;
  logic              done_s;
  logic              pass_s;

  // Compare the sampled gate output with the reference for the current vector.
  always_comb begin
    expected_s    = tt_expected(TT_PAD, 4'(idx_r));
    mismatch_s    = (gate_y != expected_s);
    settle_last_s = (settle_r == SETTLE_LAST);
    idx_last_s    = (idx_r == IDX_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start only matters while idle or finished.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      ST_WAIT: begin
        if (settle_last_s) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (idx_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Vector index, settle counter and scoring registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= {N_IN{1'b0}};
      settle_r     <= {CNT_W{1'b0}};
      err_count_r  <= {(N_IN+1){1'b0}};
      first_fail_r <= {N_IN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx_r        <= {N_IN{1'b0}};
            settle_r     <= {CNT_W{1'b0}};
            err_count_r  <= {(N_IN+1){1'b0}};
            first_fail_r <= {N_IN{1'b0}};
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_WAIT: begin
          // Saturate at the last count so the counter never needs extra width.
          if (!settle_last_s) begin
            settle_r <= settle_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            settle_r <= settle_r;
          end
        end
        ST_CHECK: begin
          if (mismatch_s) begin
            err_count_r <= err_count_r + {{N_IN{1'b0}}, 1'b1};
            if (err_count_r == {(N_IN+1){1'b0}}) begin
              first_fail_r <= idx_r;
            end else begin
              first_fail_r <= first_fail_r;
            end
          end else begin
            err_count_r <= err_count_r;
          end
          if (!idx_last_s) begin
            idx_r    <= idx_r + {{(N_IN-1){1'b0}}, 1'b1};
            settle_r <= {CNT_W{1'b0}};
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Status decode from the registered state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    pass_s = 1'b0;
    case (state_r)
      ST_WAIT, ST_CHECK: busy_s = 1'b1;
      ST_DONE: begin
        done_s = 1'b1;
        pass_s = (err_count_r == {(N_IN+1){1'b0}});
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign gate_in        = idx_r;
  assign busy           = busy_s;
  assign done           = done_s;
  assign pass           = pass_s;
  assign err_count      = err_count_r;
  assign first_fail_idx = first_fail_r;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Scoreboard bench: stimulus queues the expected sweep results, negedge
// monitors pop and compare when done rises and track gate_in while busy.
module tb_gate_sweep_controller;
  import gate_sweep_pkg::*;

  typedef struct {
    int pass;
    int errs;
    int ffi;
    int done_cyc;
    int last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_x;
  logic [1:0] gate_in_a, gate_in_x;
  logic       gate_y_a, gate_y_x;
  logic       busy_a, done_a, pass_a, busy_x, done_x, pass_x;
  logic [2:0] err_a, err_x;
  logic [1:0] ffi_a, ffi_x;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode_a = 0;
  int   acc_a = 0, acc_x = 0;
  bit   acc_a_on = 0, acc_x_on = 0;
  logic done_a_prev = 1'b0, done_x_prev = 1'b0;
  exp_t qa[$];
  exp_t qx[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: real AND gate, 1: stuck at 0, 2: stuck at 1
  assign gate_y_a = (mode_a == 0) ? (gate_in_a[0] & gate_in_a[1]) :
                    (mode_a == 1) ? 1'b0 : 1'b1;
  assign gate_y_x = gate_in_x[0] ^ gate_in_x[1];

  gate_sweep_controller dut_a (
    .clk(clk), .rst(rst), .start(start_a), .gate_in(gate_in_a), .gate_y(gate_y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail_idx(ffi_a)
  );

  gate_sweep_controller #(.N_IN(2), .EXP_TT(TT_XOR2), .SETTLE(3)) dut_x (
    .clk(clk), .rst(rst), .start(start_x), .gate_in(gate_in_x), .gate_y(gate_y_x),
    .busy(busy_x), .done(done_x), .pass(pass_x), .err_count(err_x), .first_fail_idx(ffi_x)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (!rst && done_a && !done_a_prev) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_pass", pass_a, e.pass);
        chk("a_err_count", err_a, e.errs);
        chk("a_first_fail", ffi_a, e.ffi);
        chk("a_done_cycle", cyc, e.done_cyc);
        chk("a_last_vector", gate_in_a, e.last);
        chk("a_busy_in_done", busy_a, 0);
      end
    end
    if (!rst && acc_a_on && busy_a) chk("a_gate_in", gate_in_a, (cyc - acc_a) / 2);
    done_a_prev <= done_a;
  end

  // Monitor for the XOR / SETTLE=3 instance.
  always @(negedge clk) begin
    if (!rst && done_x && !done_x_prev) begin
      if (qx.size() == 0) begin
        chk("x_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = qx.pop_front();
        chk("x_pass", pass_x, e.pass);
        chk("x_err_count", err_x, e.errs);
        chk("x_first_fail", ffi_x, e.ffi);
        chk("x_done_cycle", cyc, e.done_cyc);
        chk("x_last_vector", gate_in_x, e.last);
      end
    end
    if (!rst && acc_x_on && busy_x) chk("x_gate_in", gate_in_x, (cyc - acc_x) / 4);
    done_x_prev <= done_x;
  end

  // Called at a negedge; start is accepted on the following edge.
  task automatic pulse_a(input int p, input int e, input int f, input int m, input bit push);
    mode_a   = m;
    start_a  = 1'b1;
    acc_a    = cyc + 1;
    acc_a_on = 1'b1;
    if (push) qa.push_back('{p, e, f, cyc + 1 + 8, 3});
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int max);
    int n = 0;
    while (!done_a && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) chk("a_done_timeout", 0, 1);
  endtask

  task automatic wait_done_x(input int max);
    int n = 0;
    while (!done_x && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!done_x) chk("x_done_timeout", 0, 1);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_gate_in"}, gate_in_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_err_count"}, err_a, 0);
    chk({tag, "_first_fail"}, ffi_a, 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_x = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_a("reset");
    chk("reset_x_busy", busy_x, 0);
    chk("reset_x_done", done_x, 0);

    // AND gate, clean sweep
    pulse_a(1, 0, 0, 0, 1'b1);
    wait_done_a(40);
    @(negedge clk);

    // stuck at 0: only vector 3 fails
    pulse_a(0, 1, 3, 1, 1'b1);
    wait_done_a(40);
    @(negedge clk);

    // stuck at 1: vectors 0,1,2 fail
    pulse_a(0, 3, 0, 2, 1'b1);
    wait_done_a(40);
    @(negedge clk);

    // reset sampled on accept edge + 5, then a clean sweep
    pulse_a(1, 0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    acc_a_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_a("midrst");
    @(negedge clk);
    pulse_a(1, 0, 0, 0, 1'b1);
    wait_done_a(40);
    @(negedge clk);

    // start re-pulsed at accept+2 and accept+4 is ignored
    pulse_a(0, 1, 3, 1, 1'b1);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done_a(40);
    @(negedge clk);

    // restart from DONE clears results on the accepting edge
    pulse_a(1, 0, 0, 0, 1'b1);
    chk("restart_done", done_a, 0);
    chk("restart_pass", pass_a, 0);
    chk("restart_err_count", err_a, 0);
    chk("restart_busy", busy_a, 1);
    wait_done_a(40);
    @(negedge clk);

    // XOR gate with SETTLE=3: 4 cycles per vector, done after 16 edges
    start_x  = 1'b1;
    acc_x    = cyc + 1;
    acc_x_on = 1'b1;
    qx.push_back('{1, 0, 0, cyc + 1 + 16, 3});
    @(negedge clk);
    start_x = 1'b0;
    wait_done_x(60);

    repeat (3) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("x_queue_drained", qx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
